systolic_feeder: RTL and testbench

- Control and skew stage directly upstream of the NxN systolic MAC array.
- Accepts one row vector and one column vector per beat over a valid/ready stream and skews lane i by i steps.
- Drives the array's enable (input_valid), clear (reset) and drain (mult_over) controls.
- During drain, returns the array's results as N result beats on a valid/ready stream.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_skew_line.sv | 44 ++++
 rtl/systolic_feeder.sv | 176 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
//   ELEM_W   : element width of one array lane (fixed by the array PE)
//   state_t  : feeder control state
//   lane_lo  : bit offset of a lane inside a packed N*ELEM_W bus
package systolic_pkg;

  localparam int ELEM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Low bit of lane `lane` in a packed bus of ELEM_W-wide lanes.
  function automatic int lane_lo(input int lane);
    return lane * ELEM_W;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Per-lane delay line that skews operands into the systolic array.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : shift enable (one array step)
//   clr        : synchronous clear of every stage
//   d          : lane input
//   q          : lane output, d delayed by DEPTH enabled steps
// DEPTH=0 degenerates to a plain wire.
module systolic_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
      // Control inputs have no meaning for a zero-depth lane.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst_n, en, clr};
    end else begin : g_shift
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else if (en) begin
          sr[0] <= d;
          for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Control and skew stage in front of an NxN output-stationary systolic
// MAC array.
//   CLOCK, reset_n      : clock, asynchronous active-low reset
//   start, k_len        : job request (sampled in IDLE) and operand beat count
//   busy, done          : job in progress / one-cycle completion pulse
//   s_valid/s_ready     : operand stream, s_row and s_col carry N lanes each
//   arr_*               : array controls, skewed lanes, drain shift-in, results
//   m_valid/m_ready     : result stream, m_data is one array row per beat
//   state_dbg           : current control state
// Handshakes: a beat transfers on a cycle where valid && ready; the
// producer holds data stable while valid is high and not yet accepted.
// Here s_ready is a pure state decode (high throughout FEED) and m_valid
// is high throughout the result beats of DRAIN.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = ELEM_W,
  parameter int KW = 16
) (
  input  logic          CLOCK,
  input  logic          reset_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [N*W-1:0] s_row,
  input  logic [N*W-1:0] s_col,
  output logic          arr_reset,
  output logic          arr_input_valid,
  output logic          arr_mult_over,
  output logic [N*W-1:0] arr_in_row,
  output logic [N*W-1:0] arr_in_col,
  output logic [N*W-1:0] arr_in_data,
  input  logic [N*W-1:0] arr_out_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [N*W-1:0] m_data,
  output state_t        state_dbg
);

  localparam int CW = $clog2(2 * N);
  // Flush runs 2N-1 steps: the skew tail (N-1), the array diagonal (N-1)
  // and the PE operand register (1).
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);
  // Drain counter reaching N marks the single done cycle.
  localparam logic [CW-1:0] DRAIN_END  = CW'(N);

  state_t        state, state_nxt;
  logic [KW-1:0] k_len_q, k_len_nxt;
  logic [KW-1:0] beat_cnt, beat_nxt;
  logic [CW-1:0] phase_cnt, phase_nxt;

  logic clear;
  logic feeding;

  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      k_len_q   <= k_len_nxt;
      beat_cnt  <= beat_nxt;
      phase_cnt <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    k_len_nxt       = k_len_q;
    beat_nxt        = beat_cnt;
    phase_nxt       = phase_cnt;
    busy            = (state != ST_IDLE);
    done            = 1'b0;
    s_ready         = 1'b0;
    arr_input_valid = 1'b0;
    arr_mult_over   = 1'b0;
    m_valid         = 1'b0;
    clear           = 1'b0;
    feeding         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          k_len_nxt = k_len;
          beat_nxt  = '0;
          phase_nxt = '0;
          state_nxt = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        clear     = 1'b1;
        state_nxt = (k_len_q == '0) ? ST_FLUSH : ST_FEED;
      end

      ST_FEED: begin
        s_ready         = 1'b1;
        feeding         = 1'b1;
        arr_input_valid = s_valid;
        if (s_valid) begin
          beat_nxt = beat_cnt + KW'(1);
          if (beat_cnt == k_len_q - KW'(1)) begin
            phase_nxt = '0;
            state_nxt = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        arr_input_valid = 1'b1;
        if (phase_cnt == FLUSH_LAST) begin
          phase_nxt = '0;
          state_nxt = ST_DRAIN;
        end else begin
          phase_nxt = phase_cnt + CW'(1);
        end
      end

      ST_DRAIN: begin
        arr_mult_over = 1'b1;
        if (phase_cnt == DRAIN_END) begin
          // All N rows delivered: one done cycle, then back to IDLE.
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          m_valid         = 1'b1;
          arr_input_valid = m_ready;
          if (m_ready) phase_nxt = phase_cnt + CW'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // The array is cleared both during reset and in the CLEAR cycle.
  assign arr_reset   = ~reset_n | clear;
  assign arr_in_data = '0;
  assign m_data      = arr_out_data;
  assign state_dbg   = state;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] row_d;
    logic [W-1:0] col_d;

    // Lanes carry operands only while feeding; zeros otherwise so the
    // flush pushes nothing but zeros behind the last beat.
    assign row_d = feeding ? s_row[lane_lo(i) +: W] : '0;
    assign col_d = feeding ? s_col[lane_lo(i) +: W] : '0;

    systolic_skew_line #(.DEPTH(i), .W(W)) u_row (
      .clk   (CLOCK),
      .rst_n (reset_n),
      .en    (arr_input_valid),
      .clr   (clear),
      .d     (row_d),
      .q     (arr_in_row[lane_lo(i) +: W])
    );

    systolic_skew_line #(.DEPTH(i), .W(W)) u_col (
      .clk   (CLOCK),
      .rst_n (reset_n),
      .en    (arr_input_valid),
      .clr   (clear),
      .d     (col_d),
      .q     (arr_in_col[lane_lo(i) +: W])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder with a behavioural NxN array
// attached and a matrix-product reference for the expected results.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int KW = 16;
  localparam int NW = N * W;

  // ---------------- clock / reset ----------------
  logic CLOCK   = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [NW-1:0] s_row = '0, s_col = '0;
  logic          arr_reset, arr_input_valid, arr_mult_over;
  logic [NW-1:0] arr_in_row, arr_in_col, arr_in_data, arr_out_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [NW-1:0] m_data;
  state_t        state_dbg;

  systolic_feeder #(.N(N), .W(W), .KW(KW)) dut (
    .CLOCK           (CLOCK),
    .reset_n         (reset_n),
    .start           (start),
    .k_len           (k_len),
    .busy            (busy),
    .done            (done),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_row           (s_row),
    .s_col           (s_col),
    .arr_reset       (arr_reset),
    .arr_input_valid (arr_input_valid),
    .arr_mult_over   (arr_mult_over),
    .arr_in_row      (arr_in_row),
    .arr_in_col      (arr_in_col),
    .arr_in_data     (arr_in_data),
    .arr_out_data    (arr_out_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .state_dbg       (state_dbg)
  );

  // ---------------- array model ----------------
  // Output-stationary PEs with a registered operand pair; MAC uses the
  // registered operands. In drain mode rows shift up toward row 0.
  logic [W-1:0] acc  [N][N];
  logic [W-1:0] areg [N][N];
  logic [W-1:0] breg [N][N];

  always @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n || arr_reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0; areg[i][j] <= '0; breg[i][j] <= '0;
        end
    end else if (arr_input_valid) begin
      if (arr_mult_over) begin
        for (int c = 0; c < N; c++) begin
          for (int i = 0; i < N - 1; i++) acc[i][c] <= acc[i+1][c];
          acc[N-1][c] <= arr_in_data[c*W +: W];
        end
      end else begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            acc[i][j]  <= acc[i][j] + W'(areg[i][j] * breg[i][j]);
            areg[i][j] <= (j == 0) ? arr_in_row[i*W +: W] : areg[i][(j == 0) ? 0 : j-1];
            breg[i][j] <= (i == 0) ? arr_in_col[j*W +: W] : breg[(i == 0) ? 0 : i-1][j];
          end
      end
    end
  end

  always_comb begin
    arr_out_data = '0;
    for (int c = 0; c < N; c++) arr_out_data[c*W +: W] = acc[0][c];
  end

  int done_cnt = 0;
  always @(posedge CLOCK) if (done === 1'b1) done_cnt++;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [NW-1:0] rows[$];
  logic [NW-1:0] cols[$];
  logic [NW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // C = A * B mod 256, A[i][k] = lane i of row beat k, B[k][j] = lane j of col beat k.
  task automatic build_exp(input int kl);
    logic [NW-1:0] r, c, e;
    int sum;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      e = '0;
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < kl; k++) begin
          r = rows[k]; c = cols[k];
          sum += int'(r[i*W +: W]) * int'(c[j*W +: W]);
        end
        e[j*W +: W] = W'(sum % 256);
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [NW-1:0] skew_vec(input int s);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i == s) v[i*W +: W] = 8'd1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic fill_random(input int kl);
    rows.delete(); cols.delete();
    for (int k = 0; k < kl; k++) begin
      rows.push_back(NW'($urandom));
      cols.push_back(NW'($urandom));
    end
  endtask

  task automatic fill_const(input int kl, input logic [W-1:0] v);
    rows.delete(); cols.delete();
    for (int k = 0; k < kl; k++) begin
      rows.push_back({N{v}});
      cols.push_back({N{v}});
    end
  endtask

  // Runs one complete job; called at a falling edge with the DUT idle.
  task automatic run_job(input string name, input int kl, input int feed_stall_at,
                         input int drain_stall_at, input bit start_in_flush, input bit skew_chk);
    int d0, fs;
    logic [NW-1:0] e;
    build_exp(kl);
    d0 = done_cnt;

    start = 1'b1; k_len = KW'(kl); #1;
    chk({name, ":idle_busy"}, 64'(busy), 64'(0));
    chk({name, ":idle_s_ready"}, 64'(s_ready), 64'(0));
    cyc();
    start = 1'b0; #1;
    chk({name, ":clear_arr_reset"}, 64'(arr_reset), 64'(1));
    chk({name, ":clear_busy"}, 64'(busy), 64'(1));
    chk({name, ":clear_no_step"}, 64'(arr_input_valid), 64'(0));
    cyc();

    for (int k = 0; k < kl; k++) begin
      if (k == feed_stall_at) begin
        s_valid = 1'b0;
        repeat (3) begin
          #1 chk({name, ":feed_stall_hold"}, 64'(arr_input_valid), 64'(0));
          cyc();
        end
      end
      s_valid = 1'b1; s_row = rows[k]; s_col = cols[k]; #1;
      chk({name, ":feed_ready"}, 64'(s_ready), 64'(1));
      chk({name, ":feed_step"}, 64'(arr_input_valid), 64'(1));
      if (skew_chk) begin
        chk({name, ":skew_row_0"}, 64'(arr_in_row), 64'(skew_vec(0)));
        chk({name, ":skew_col_0"}, 64'(arr_in_col), 64'(skew_vec(0)));
      end
      cyc();
    end
    // Junk on the operand bus outside FEED must not reach the array.
    s_valid = 1'b0; s_row = NW'($urandom); s_col = NW'($urandom);

    fs = 0;
    for (int t = 0; t < 40; t++) begin
      start = (start_in_flush && t == 1); #1;
      if (m_valid === 1'b1) break;
      chk({name, ":flush_step"}, 64'(arr_input_valid), 64'(1));
      chk({name, ":flush_mult_over"}, 64'(arr_mult_over), 64'(0));
      if (skew_chk) begin
        chk({name, ":skew_row"}, 64'(arr_in_row), 64'(skew_vec(fs + 1)));
        chk({name, ":skew_col"}, 64'(arr_in_col), 64'(skew_vec(fs + 1)));
      end
      fs++;
      cyc();
    end
    start = 1'b0;
    chk({name, ":flush_len"}, 64'(fs), 64'(2 * N - 1));

    for (int j = 0; j < N; j++) begin
      e = exp_q[j];
      if (j == drain_stall_at) begin
        m_ready = 1'b0;
        repeat (5) begin
          #1;
          chk({name, ":drain_stall_step"}, 64'(arr_input_valid), 64'(0));
          chk({name, ":drain_stall_valid"}, 64'(m_valid), 64'(1));
          chk({name, ":drain_stall_data"}, 64'(m_data), 64'(e));
          cyc();
        end
      end
      m_ready = 1'b1; #1;
      chk({name, ":drain_valid"}, 64'(m_valid), 64'(1));
      chk({name, ":drain_mult_over"}, 64'(arr_mult_over), 64'(1));
      chk({name, ":drain_step"}, 64'(arr_input_valid), 64'(1));
      chk({name, ":drain_data"}, 64'(m_data), 64'(e));
      cyc();
    end

    m_ready = 1'b0; #1;
    chk({name, ":done_pulse"}, 64'(done), 64'(1));
    chk({name, ":done_busy"}, 64'(busy), 64'(1));
    chk({name, ":done_no_valid"}, 64'(m_valid), 64'(0));
    cyc(); #1;
    chk({name, ":after_done"}, 64'(done), 64'(0));
    chk({name, ":after_idle"}, 64'(busy), 64'(0));
    chk({name, ":done_count"}, 64'(done_cnt - d0), 64'(1));
    cyc();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, kl;

    #1;
    chk("reset_arr_reset", 64'(arr_reset), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_s_ready", 64'(s_ready), 64'(0));
    chk("reset_m_valid", 64'(m_valid), 64'(0));
    chk("reset_step", 64'(arr_input_valid), 64'(0));
    @(negedge CLOCK); @(negedge CLOCK);
    reset_n = 1'b1;
    cyc(); #1;
    chk("post_reset_arr_reset", 64'(arr_reset), 64'(0));
    chk("post_reset_done", 64'(done), 64'(0));
    cyc();

    // Identity A (one-hot row beats) times B = 1..16.
    rows.delete(); cols.delete();
    for (int k = 0; k < N; k++) begin
      logic [NW-1:0] r, c;
      r = '0; c = '0;
      r[k*W +: W] = 8'd1;
      for (int j = 0; j < N; j++) c[j*W +: W] = W'(k * N + j + 1);
      rows.push_back(r); cols.push_back(c);
    end
    run_job("ident", N, -1, -1, 1'b0, 1'b0);

    fill_const(1, 8'h01);
    run_job("skew", 1, -1, -1, 1'b0, 1'b1);

    fill_random(5);
    run_job("bp_nostall", 5, -1, -1, 1'b0, 1'b0);
    run_job("bp_stall", 5, 2, 1, 1'b0, 1'b0);

    fill_const(2, 8'h10);
    run_job("wrap", 2, -1, -1, 1'b0, 1'b0);

    rows.delete(); cols.delete();
    run_job("zero_len", 0, -1, -1, 1'b0, 1'b0);

    fill_random(3);
    run_job("start_in_flush", 3, -1, -1, 1'b1, 1'b0);

    // Reset in the middle of FEED abandons the job silently.
    fill_random(4);
    d0 = done_cnt;
    start = 1'b1; k_len = KW'(4); cyc();
    start = 1'b0; cyc();
    s_valid = 1'b1; s_row = rows[0]; s_col = cols[0]; cyc();
    s_row = rows[1]; s_col = cols[1]; cyc();
    reset_n = 1'b0; #1;
    chk("midreset_arr_reset", 64'(arr_reset), 64'(1));
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_s_ready", 64'(s_ready), 64'(0));
    chk("midreset_step", 64'(arr_input_valid), 64'(0));
    chk("midreset_mult_over", 64'(arr_mult_over), 64'(0));
    chk("midreset_m_valid", 64'(m_valid), 64'(0));
    chk("midreset_done", 64'(done), 64'(0));
    chk("midreset_in_row", 64'(arr_in_row), 64'(0));
    chk("midreset_in_col", 64'(arr_in_col), 64'(0));
    cyc();
    s_valid = 1'b0; reset_n = 1'b1;
    repeat (3) cyc();
    #1;
    chk("midreset_idle", 64'(busy), 64'(0));
    chk("midreset_no_done", 64'(done_cnt - d0), 64'(0));
    cyc();

    for (int r = 0; r < 4; r++) begin
      kl = $urandom_range(1, 8);
      fill_random(kl);
      run_job("random", kl, $urandom_range(0, kl), $urandom_range(0, N), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
